ifetch_queue: RTL and testbench

Parametrised next-generation instruction fetch stage. It keeps the PC, queries a BHT of configurable size and counter width, and redirects on conditional branches and, optionally, on JAL. Fetched instructions are buffered in an instruction queue and handed to issue through a valid/ready handshake, so back-end stalls no longer stall fetch directly. It sits between the instruction cache and issue/decode; the ROB drives the flush and the predictor update ports.

---
 rtl/ifetch_queue.sv | 164 ++++++++++++++++
 tb/tb_ifetch_queue.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: PC + BHT-based next-PC prediction, with a
// small instruction queue decoupling fetch from issue via valid/ready.
module ifetch_queue #(
    parameter int          IQ_DEPTH_LOG = 2,
    parameter int          BHT_IDX_W    = 8,
    parameter int          CNT_W        = 2,
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter bit          PRED_JAL     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic [31:0] pc_to_ic,
    output logic        ic_req,
    input  logic        inst_valid,
    input  logic [31:0] inst_from_ic,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_pred,
    input  logic        jump_flag,
    input  logic [31:0] target_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken
);

    localparam int DEPTH = 1 << IQ_DEPTH_LOG;
    localparam int BHT_N = 1 << BHT_IDX_W;
    localparam logic [IQ_DEPTH_LOG:0] FULL_CNT = DEPTH[IQ_DEPTH_LOG:0];
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [31:0] pc;
    logic [IQ_DEPTH_LOG-1:0] head;
    logic [IQ_DEPTH_LOG-1:0] tail;
    logic [IQ_DEPTH_LOG:0]   count;

    logic [31:0] q_inst [DEPTH];
    logic [31:0] q_pc   [DEPTH];
    logic        q_pred [DEPTH];

    logic [CNT_W-1:0] bht [BHT_N];

    logic full;
    logic push;
    logic pop;
    logic flush;

    logic [BHT_IDX_W-1:0] look_idx;
    logic [BHT_IDX_W-1:0] upd_idx;
    logic                 bht_taken;

    logic [6:0]  opcode;
    logic [31:0] b_imm;
    logic [31:0] j_imm;
    logic        is_branch;
    logic        is_jal;
    logic        pred;
    logic [31:0] next_pc;

    logic unused_upd_bits;

    assign full  = (count == FULL_CNT);
    assign flush = rdy && jump_flag;
    assign push  = rdy && inst_valid && !jump_flag && !full;
    assign pop   = out_valid && out_ready && !jump_flag;

    assign ic_req    = rdy && !full && !jump_flag;
    assign pc_to_ic  = pc;
    assign out_valid = rdy && (count != '0);
    assign out_inst  = q_inst[head];
    assign out_pc    = q_pc[head];
    assign out_pred  = q_pred[head];

    // Lookup reads the registered table, so a same-cycle update is not seen.
    assign look_idx  = pc[BHT_IDX_W+1:2];
    assign upd_idx   = upd_pc[BHT_IDX_W+1:2];
    assign bht_taken = bht[look_idx][CNT_W-1];

    assign unused_upd_bits = ^{upd_pc[31:BHT_IDX_W+2], upd_pc[1:0]};

    assign opcode    = inst_from_ic[6:0];
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);

    assign b_imm = {{19{inst_from_ic[31]}}, inst_from_ic[31],
                    inst_from_ic[7], inst_from_ic[30:25],
                    inst_from_ic[11:8], 1'b0};
    assign j_imm = {{11{inst_from_ic[31]}}, inst_from_ic[31],
                    inst_from_ic[19:12], inst_from_ic[20],
                    inst_from_ic[30:21], 1'b0};

    always_comb begin
        pred    = 1'b0;
        next_pc = pc + 32'd4;
        if (is_branch && bht_taken) begin
            pred    = 1'b1;
            next_pc = pc + b_imm;
        end else if (is_jal && PRED_JAL) begin
            pred    = 1'b1;
            next_pc = pc + j_imm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            pc    <= target_pc;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (push) begin
                pc   <= next_pc;
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_inst[i] <= '0;
                q_pc[i]   <= '0;
                q_pred[i] <= 1'b0;
            end
        end else if (push) begin
            q_inst[tail] <= inst_from_ic;
            q_pc[tail]   <= pc;
            q_pred[tail] <= pred;
        end
    end

    // Saturating counter update, independent of flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht[i] <= '0;
            end
        end else if (rdy && upd_valid) begin
            if (upd_taken && bht[upd_idx] != CNT_MAX) begin
                bht[upd_idx] <= bht[upd_idx] + 1'b1;
            end else if (!upd_taken && bht[upd_idx] != '0) begin
                bht[upd_idx] <= bht[upd_idx] - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: stimulus pushes expected entries,
// a negedge monitor pops and compares whenever issue takes the head.
module tb_ifetch_queue;

    localparam logic [31:0] ADDI = 32'h00100093;
    localparam logic [31:0] BEQ_M4 = 32'hFE000EE3;
    localparam logic [31:0] JAL_100 = 32'h1000006F;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        inst_valid = 1'b0;
    logic [31:0] inst_from_ic = '0;
    logic        out_ready = 1'b0;
    logic        jump_flag = 1'b0;
    logic [31:0] target_pc = '0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;

    logic [31:0] pc_to_ic, out_inst, out_pc;
    logic        ic_req, out_valid, out_pred;
    logic [31:0] pc_b, inst_b, opc_b;
    logic        req_b, val_b, pred_b;

    int checks = 0;
    int failures = 0;
    entry_t exp_q[$];

    always #5 clk = ~clk;

    ifetch_queue #(.PRED_JAL(1'b1)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .pc_to_ic(pc_to_ic), .ic_req(ic_req),
        .inst_valid(inst_valid), .inst_from_ic(inst_from_ic),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .out_pred(out_pred),
        .jump_flag(jump_flag), .target_pc(target_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken)
    );

    ifetch_queue #(.PRED_JAL(1'b0)) dut_nojal (
        .clk(clk), .rst(rst), .rdy(rdy),
        .pc_to_ic(pc_b), .ic_req(req_b),
        .inst_valid(inst_valid), .inst_from_ic(inst_from_ic),
        .out_valid(val_b), .out_ready(out_ready),
        .out_inst(inst_b), .out_pc(opc_b), .out_pred(pred_b),
        .jump_flag(jump_flag), .target_pc(target_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_push(input logic [31:0] i, input logic [31:0] p,
                               input logic pr);
        entry_t e;
        e.inst = i;
        e.pc = p;
        e.pred = pr;
        exp_q.push_back(e);
    endtask

    task automatic flush_to(input logic [31:0] t);
        jump_flag = 1'b1;
        target_pc = t;
        step();
        jump_flag = 1'b0;
        exp_q.delete();
    endtask

    task automatic train(input logic taken, input int n);
        upd_valid = 1'b1;
        upd_pc = 32'h4;
        upd_taken = taken;
        repeat (n) step();
        upd_valid = 1'b0;
    endtask

    // Fetch BEQ -4 at pc 4; optionally train taken in the same cycle.
    task automatic probe(input logic exp_pred, input logic with_upd);
        flush_to(32'h4);
        inst_valid = 1'b1;
        inst_from_ic = BEQ_M4;
        if (with_upd) begin
            upd_valid = 1'b1;
            upd_pc = 32'h4;
            upd_taken = 1'b1;
        end
        expect_push(BEQ_M4, 32'h4, exp_pred);
        step();
        inst_valid = 1'b0;
        upd_valid = 1'b0;
        check("beq_next_pc", pc_to_ic, exp_pred ? 32'h0 : 32'h8);
        step();
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !jump_flag) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected: got pc %h expected none",
                         out_pc);
            end else begin
                entry_t e;
                e = exp_q.pop_front();
                check("pop_inst", out_inst, e.inst);
                check("pop_pc", out_pc, e.pc);
                check("pop_pred", {31'b0, out_pred}, {31'b0, e.pred});
            end
        end
    end

    initial begin
        #3;
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_pc", pc_to_ic, 32'h0);
        check("rst_out_inst", out_inst, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_pred", {31'b0, out_pred}, 32'h0);
        check("rst_ic_req", {31'b0, ic_req}, 32'h1);
        #9;
        rst = 1'b0;
        step();

        inst_valid = 1'b1;
        inst_from_ic = ADDI;
        for (int i = 0; i < 4; i++) begin
            expect_push(ADDI, 32'(4 * i), 1'b0);
            step();
        end
        check("full_pc", pc_to_ic, 32'd16);
        check("full_ic_req", {31'b0, ic_req}, 32'h0);
        check("full_out_valid", {31'b0, out_valid}, 32'h1);
        step();
        check("full_refused_pc", pc_to_ic, 32'd16);

        inst_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) step();
        inst_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_push(ADDI, 32'(16 + 4 * i), 1'b0);
            step();
        end
        check("pp_out_valid", {31'b0, out_valid}, 32'h1);
        check("pp_pc", pc_to_ic, 32'd28);
        inst_valid = 1'b0;
        repeat (2) step();
        check("drain_out_valid", {31'b0, out_valid}, 32'h0);

        probe(1'b0, 1'b0);
        train(1'b1, 2);
        probe(1'b1, 1'b0);
        train(1'b1, 2);
        train(1'b0, 1);
        probe(1'b1, 1'b0);
        train(1'b0, 1);
        probe(1'b0, 1'b0);
        train(1'b0, 2);
        train(1'b1, 1);
        probe(1'b0, 1'b0);
        probe(1'b0, 1'b1);
        probe(1'b1, 1'b0);

        flush_to(32'h20);
        inst_valid = 1'b1;
        inst_from_ic = JAL_100;
        expect_push(JAL_100, 32'h20, 1'b1);
        step();
        inst_valid = 1'b0;
        check("jal_pc", pc_to_ic, 32'h120);
        check("nojal_pc", pc_b, 32'h24);
        check("nojal_pred", {31'b0, pred_b}, 32'h0);
        step();

        out_ready = 1'b0;
        flush_to(32'h0);
        inst_valid = 1'b1;
        inst_from_ic = ADDI;
        repeat (3) step();
        check("pre_flush_valid", {31'b0, out_valid}, 32'h1);
        jump_flag = 1'b1;
        target_pc = 32'h80;
        out_ready = 1'b1;
        step();
        jump_flag = 1'b0;
        inst_valid = 1'b0;
        check("flush_out_valid", {31'b0, out_valid}, 32'h0);
        check("flush_pc", pc_to_ic, 32'h80);
        inst_valid = 1'b1;
        expect_push(ADDI, 32'h80, 1'b0);
        step();
        inst_valid = 1'b0;
        step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        out_ready = 1'b0;
        inst_valid = 1'b1;
        repeat (2) step();
        rdy = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rdy0_out_valid", {31'b0, out_valid}, 32'h0);
            check("rdy0_ic_req", {31'b0, ic_req}, 32'h0);
            check("rdy0_pc", pc_to_ic, 32'h8C);
        end
        inst_valid = 1'b0;
        out_ready = 1'b0;
        rdy = 1'b1;
        #1;
        check("rdy1_out_valid", {31'b0, out_valid}, 32'h1);
        check("rdy1_out_pc", out_pc, 32'h84);
        #1;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("arst_out_valid", {31'b0, out_valid}, 32'h0);
        check("arst_pc", pc_to_ic, 32'h0);
        check("arst_out_pc", out_pc, 32'h0);
        check("arst_out_inst", out_inst, 32'h0);
        step();
        rst = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
